// File: rtl/rgb_paleta.sv
// rgb_paleta: pixel colouring for a clock/date display.
// Classifies each pixel (blank, border, highlighted text, font, background),
// looks its colour up in a five-entry writable palette and presents it two
// clocks after the pixel inputs.
//
// Ports:
//   clk, resetM                 pixel clock, synchronous active-high reset
//   P_FECHA, P_HORA, P_CRONO    active-field selects (pick highlighted text)
//   A_A                         edit mode, enables blinking of highlighted text
//   H_ON, V_ON                  visible-region flags
//   Qh, Qv                      current pixel column / row
//   BIT_FUENTE                  font pixel at (Qh,Qv)
//   pal_we/pal_addr/pal_data    palette write request (held until pal_ack)
//   pal_ack                     one-cycle write acknowledge
//   R, G, B                     pixel colour
//   Impresion                   pixel is ink (border, font or highlight)
//   ON_d                        H_ON&V_ON aligned with R/G/B
module rgb_paleta #(
  parameter int CW           = 4,
  parameter int HB0          = 48,
  parameter int HB1          = 684,
  parameter int HBW          = 4,
  parameter int VB0          = 33,
  parameter int VB0W         = 2,
  parameter int VB1          = 511,
  parameter int VB1W         = 3,
  parameter int BLINK_FRAMES = 30
) (
  input  logic            clk,
  input  logic            resetM,
  input  logic            P_FECHA,
  input  logic            P_HORA,
  input  logic            P_CRONO,
  input  logic            A_A,
  input  logic            H_ON,
  input  logic            V_ON,
  input  logic [9:0]      Qh,
  input  logic [9:0]      Qv,
  input  logic            BIT_FUENTE,
  input  logic            pal_we,
  input  logic [2:0]      pal_addr,
  input  logic [3*CW-1:0] pal_data,
  output logic            pal_ack,
  output logic [CW-1:0]   R,
  output logic [CW-1:0]   G,
  output logic [CW-1:0]   B,
  output logic            Impresion,
  output logic            ON_d
);

  // Class codes double as palette indices.
  typedef enum logic [2:0] {
    CL_BACK   = 3'd0,
    CL_FONT   = 3'd1,
    CL_HILITE = 3'd2,
    CL_BORDER = 3'd3,
    CL_BLANK  = 3'd4
  } pix_class_t;

  localparam int CNTW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(BLINK_FRAMES - 1);

  // Rescale a 4-bit design colour nibble to CW bits (truncating).
  function automatic logic [CW-1:0] scale(input int v);
    int s;
    s = v * ((1 << CW) - 1) / 15;
    return s[CW-1:0];
  endfunction

  function automatic logic [3*CW-1:0] pal_default(input int idx);
    case (idx)
      0:       return {scale(12), scale(15), scale(9)};
      1:       return {scale(3),  scale(3),  scale(3)};
      2:       return {scale(0),  scale(9),  scale(4)};
      3:       return {scale(3),  scale(6),  scale(0)};
      default: return '0;
    endcase
  endfunction

  // Half-open unsigned band test [lo, lo+w).
  function automatic logic in_band(input logic [9:0] q, input int lo, input int w);
    int qi;
    qi = int'(q);
    return (qi >= lo) && (qi < lo + w);
  endfunction

  logic            on;
  logic            border;
  logic            highlighted;
  logic            frame_tick;
  logic            accept;
  pix_class_t      class_next;

  pix_class_t      class_reg;
  logic            on_reg;
  logic [3*CW-1:0] pal_reg [0:4];
  logic            ack_reg;
  logic            prev_zero_reg;
  logic [CNTW-1:0] cnt_reg;
  logic            blink_vis_reg;
  logic [CW-1:0]   r_reg, g_reg, b_reg;
  logic            imp_reg;
  logic            on_d_reg;

  assign on          = H_ON & V_ON;
  assign border      = on & (in_band(Qh, HB0, HBW) | in_band(Qh, HB1, HBW) |
                             in_band(Qv, VB0, VB0W) | in_band(Qv, VB1, VB1W));
  assign highlighted = (P_FECHA & ~P_HORA) | (P_HORA & ~P_FECHA & P_CRONO);
  assign frame_tick  = (Qh == 10'd0) && (Qv == 10'd0) && !prev_zero_reg;
  // Gating on ack_reg spaces held requests to one write every two cycles.
  assign accept      = pal_we & ~on & ~ack_reg;

  always_comb begin
    class_next = CL_BACK;
    if (!on)
      class_next = CL_BLANK;
    else if (border)
      class_next = CL_BORDER;
    else if (BIT_FUENTE && highlighted)
      class_next = blink_vis_reg ? CL_HILITE : CL_BACK;
    else if (BIT_FUENTE)
      class_next = CL_FONT;
  end

  // Stage 1: classify.
  always_ff @(posedge clk) begin
    if (resetM) begin
      class_reg <= CL_BLANK;
      on_reg    <= 1'b0;
    end else begin
      class_reg <= class_next;
      on_reg    <= on;
    end
  end

  // Stage 2: palette lookup.
  always_ff @(posedge clk) begin
    if (resetM) begin
      r_reg    <= '0;
      g_reg    <= '0;
      b_reg    <= '0;
      imp_reg  <= 1'b0;
      on_d_reg <= 1'b0;
    end else begin
      r_reg    <= pal_reg[class_reg][3*CW-1 -: CW];
      g_reg    <= pal_reg[class_reg][2*CW-1 -: CW];
      b_reg    <= pal_reg[class_reg][CW-1:0];
      imp_reg  <= (class_reg == CL_BORDER) || (class_reg == CL_FONT) ||
                  (class_reg == CL_HILITE);
      on_d_reg <= on_reg;
    end
  end

  // Palette and write handshake; addresses 5..7 are acknowledged but ignored.
  always_ff @(posedge clk) begin
    if (resetM) begin
      for (int i = 0; i < 5; i++)
        pal_reg[i] <= pal_default(i);
      ack_reg <= 1'b0;
    end else begin
      ack_reg <= accept;
      if (accept && (pal_addr < 3'd5))
        pal_reg[pal_addr] <= pal_data;
    end
  end

  // Frame counter and blink phase.
  always_ff @(posedge clk) begin
    if (resetM) begin
      prev_zero_reg <= 1'b1;
      cnt_reg       <= '0;
      blink_vis_reg <= 1'b1;
    end else begin
      prev_zero_reg <= (Qh == 10'd0) && (Qv == 10'd0);
      if (!A_A) begin
        cnt_reg       <= '0;
        blink_vis_reg <= 1'b1;
      end else if (frame_tick) begin
        if (cnt_reg == CNT_LAST) begin
          cnt_reg       <= '0;
          blink_vis_reg <= ~blink_vis_reg;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end
    end
  end

  assign R         = r_reg;
  assign G         = g_reg;
  assign B         = b_reg;
  assign Impresion = imp_reg;
  assign ON_d      = on_d_reg;
  assign pal_ack   = ack_reg;

endmodule

// File: tb/tb_rgb_paleta.sv
// Directed testbench for rgb_paleta (CW=4, BLINK_FRAMES=2).
module tb_rgb_paleta;
  logic        clk = 1'b0;
  logic        resetM, P_FECHA, P_HORA, P_CRONO, A_A, H_ON, V_ON;
  logic [9:0]  Qh, Qv;
  logic        BIT_FUENTE, pal_we;
  logic [2:0]  pal_addr;
  logic [11:0] pal_data;
  logic        pal_ack;
  logic [3:0]  R, G, B;
  logic        Impresion, ON_d;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rgb_paleta #(.BLINK_FRAMES(2)) dut (
    .clk(clk), .resetM(resetM), .P_FECHA(P_FECHA), .P_HORA(P_HORA),
    .P_CRONO(P_CRONO), .A_A(A_A), .H_ON(H_ON), .V_ON(V_ON), .Qh(Qh), .Qv(Qv),
    .BIT_FUENTE(BIT_FUENTE), .pal_we(pal_we), .pal_addr(pal_addr),
    .pal_data(pal_data), .pal_ack(pal_ack), .R(R), .G(G), .B(B),
    .Impresion(Impresion), .ON_d(ON_d)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pix(input logic [9:0] h, input logic [9:0] v, input logic b);
    H_ON = 1'b1; V_ON = 1'b1; Qh = h; Qv = v; BIT_FUENTE = b;
  endtask

  task automatic do_reset();
    resetM = 1'b1;
    step(1);
    resetM = 1'b0;
  endtask

  // One frame boundary: a single cycle at (0,0), then back to (100,100)
  // and wait for the pipeline.
  task automatic frame_tick();
    Qh = 10'd0; Qv = 10'd0;
    step(1);
    Qh = 10'd100; Qv = 10'd100;
    step(2);
  endtask

  task automatic test_reset();
    resetM = 1'b1; P_FECHA = 0; P_HORA = 0; P_CRONO = 0; A_A = 0;
    pal_we = 0; pal_addr = 0; pal_data = 0;
    pix(10'd100, 10'd100, 1'b1);
    step(2);
    checks++;
    if ({R, G, B, Impresion, ON_d, pal_ack} !== 15'd0) begin
      errors++;
      $display("FAIL reset outputs got rgb=%h imp=%b on_d=%b ack=%b want 000/0/0/0",
               {R, G, B}, Impresion, ON_d, pal_ack);
    end
    resetM = 1'b0;
    $display("reset done");
  endtask

  task automatic test_back();
    pix(10'd100, 10'd100, 1'b0);
    step(1);
    checks++;
    if (ON_d !== 1'b0) begin
      errors++;
      $display("FAIL latency1 got on_d=%b want 0", ON_d);
    end
    step(1);
    checks++;
    if ({R, G, B, Impresion, ON_d} !== {12'hCF9, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL back got rgb=%h imp=%b on_d=%b want cf9/0/1",
               {R, G, B}, Impresion, ON_d);
    end
    $display("back pixel rgb=%h", {R, G, B});
  endtask

  task automatic test_border();
    logic [9:0]  h   [11] = '{49, 52, 47, 51, 52, 100, 100, 100, 684, 688, 687};
    logic [9:0]  v   [11] = '{100, 100, 100, 100, 34, 35, 513, 514, 100, 100, 100};
    logic        b   [11] = '{1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0};
    logic [11:0] rgb [11] = '{12'h360, 12'h333, 12'hCF9, 12'h360, 12'h360, 12'hCF9,
                              12'h360, 12'h333, 12'h360, 12'hCF9, 12'h360};
    logic        imp [11] = '{1, 1, 0, 1, 1, 0, 1, 1, 1, 0, 1};
    for (int i = 0; i < 11; i++) begin
      pix(h[i], v[i], b[i]);
      step(2);
      checks++;
      if ({R, G, B} !== rgb[i] || Impresion !== imp[i]) begin
        errors++;
        $display("FAIL border[%0d] (%0d,%0d) got rgb=%h imp=%b want %h/%b",
                 i, h[i], v[i], {R, G, B}, Impresion, rgb[i], imp[i]);
      end
      $display("pixel (%0d,%0d) rgb=%h imp=%b", h[i], v[i], {R, G, B}, Impresion);
    end
  endtask

  task automatic test_blank();
    pix(10'd49, 10'd100, 1'b1);
    H_ON = 1'b0;
    step(2);
    checks++;
    if ({R, G, B, Impresion, ON_d} !== 14'd0) begin
      errors++;
      $display("FAIL blank got rgb=%h imp=%b on_d=%b want 000/0/0",
               {R, G, B}, Impresion, ON_d);
    end
    $display("blank pixel rgb=%h", {R, G, B});
  endtask

  task automatic test_highlight();
    logic        f  [4] = '{1, 0, 0, 1};
    logic        hr [4] = '{0, 1, 1, 1};
    logic        c  [4] = '{0, 1, 0, 1};
    logic [11:0] w  [4] = '{12'h094, 12'h094, 12'h333, 12'h333};
    A_A = 1'b0;
    pix(10'd100, 10'd100, 1'b1);
    for (int i = 0; i < 4; i++) begin
      P_FECHA = f[i]; P_HORA = hr[i]; P_CRONO = c[i];
      step(2);
      checks++;
      if ({R, G, B} !== w[i]) begin
        errors++;
        $display("FAIL highlight[%0d] got rgb=%h want %h", i, {R, G, B}, w[i]);
      end
      $display("select f=%b h=%b c=%b rgb=%h", f[i], hr[i], c[i], {R, G, B});
    end
    P_FECHA = 0; P_HORA = 0; P_CRONO = 0;
  endtask

  task automatic test_blink();
    logic [11:0] w [7] = '{12'h094, 12'h094, 12'hCF9, 12'hCF9, 12'h094, 12'h094, 12'hCF9};
    H_ON = 1'b0; Qh = 10'd100; Qv = 10'd100;
    do_reset();
    P_FECHA = 1'b1; A_A = 1'b1;
    pix(10'd100, 10'd100, 1'b1);
    step(2);
    for (int i = 0; i < 7; i++) begin
      if (i > 0) frame_tick();
      checks++;
      if ({R, G, B} !== w[i]) begin
        errors++;
        $display("FAIL blink frame%0d got rgb=%h want %h", i, {R, G, B}, w[i]);
      end
      $display("blink frame %0d rgb=%h", i, {R, G, B});
    end
    A_A = 1'b0;
    step(3);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) frame_tick();
      checks++;
      if ({R, G, B} !== 12'h094) begin
        errors++;
        $display("FAIL steady%0d got rgb=%h want 094", i, {R, G, B});
      end
      $display("edit off step %0d rgb=%h", i, {R, G, B});
    end
    P_FECHA = 1'b0;
  endtask

  task automatic test_tick_and_write();
    H_ON = 1'b0; Qh = 10'd100; Qv = 10'd100;
    do_reset();
    A_A = 1'b1; P_FECHA = 1'b1;
    step(1);
    Qh = 10'd0; Qv = 10'd0;
    pal_we = 1'b1; pal_addr = 3'd2; pal_data = 12'h0F0;
    step(1);
    checks++;
    if (pal_ack !== 1'b1) begin
      errors++;
      $display("FAIL tickwrite ack got %b want 1", pal_ack);
    end
    pal_we = 1'b0;
    pix(10'd100, 10'd100, 1'b1);
    step(2);
    checks++;
    if ({R, G, B} !== 12'h0F0) begin
      errors++;
      $display("FAIL tickwrite hilite got rgb=%h want 0f0", {R, G, B});
    end
    frame_tick();
    checks++;
    if ({R, G, B} !== 12'hCF9) begin
      errors++;
      $display("FAIL tickwrite blink got rgb=%h want cf9", {R, G, B});
    end
    $display("tick+write hilite rgb=%h", {R, G, B});
    A_A = 1'b0; P_FECHA = 1'b0;
  endtask

  task automatic test_stall();
    logic exp_ack [4] = '{1, 0, 1, 0};
    do_reset();
    pix(10'd100, 10'd100, 1'b0);
    pal_we = 1'b1; pal_addr = 3'd0; pal_data = 12'hF00;
    for (int i = 0; i < 3; i++) begin
      step(1);
      checks++;
      if (pal_ack !== 1'b0) begin
        errors++;
        $display("FAIL stall%0d ack got %b want 0", i, pal_ack);
      end
    end
    checks++;
    if ({R, G, B} !== 12'hCF9) begin
      errors++;
      $display("FAIL stall colour got rgb=%h want cf9", {R, G, B});
    end
    H_ON = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) pal_we = 1'b0;
      step(1);
      checks++;
      if (pal_ack !== exp_ack[i]) begin
        errors++;
        $display("FAIL ackseq%0d got %b want %b", i, pal_ack, exp_ack[i]);
      end
      $display("blanking cycle %0d ack=%b", i, pal_ack);
    end
    pix(10'd100, 10'd100, 1'b0);
    step(2);
    checks++;
    if ({R, G, B} !== 12'hF00) begin
      errors++;
      $display("FAIL newback got rgb=%h want f00", {R, G, B});
    end
  endtask

  task automatic test_bad_addr();
    logic [9:0]  h  [5] = '{100, 52, 100, 49, 100};
    logic        b  [5] = '{0, 1, 1, 0, 0};
    logic        f  [5] = '{0, 0, 1, 0, 0};
    logic        hn [5] = '{1, 1, 1, 1, 0};
    logic [11:0] w  [5] = '{12'hF00, 12'h333, 12'h094, 12'h360, 12'h000};
    H_ON = 1'b0;
    pal_we = 1'b1; pal_addr = 3'd6; pal_data = 12'hFFF;
    step(1);
    checks++;
    if (pal_ack !== 1'b1) begin
      errors++;
      $display("FAIL badaddr ack got %b want 1", pal_ack);
    end
    pal_we = 1'b0;
    step(1);
    for (int i = 0; i < 5; i++) begin
      pix(h[i], 10'd100, b[i]);
      H_ON = hn[i]; P_FECHA = f[i];
      step(2);
      checks++;
      if ({R, G, B} !== w[i]) begin
        errors++;
        $display("FAIL entry%0d got rgb=%h want %h", i, {R, G, B}, w[i]);
      end
      $display("palette entry %0d rgb=%h", i, {R, G, B});
    end
    P_FECHA = 1'b0;
  endtask

  task automatic test_reset_mid();
    pix(10'd100, 10'd100, 1'b0);
    resetM = 1'b1;
    step(1);
    checks++;
    if ({R, G, B, Impresion, ON_d} !== 14'd0) begin
      errors++;
      $display("FAIL midreset got rgb=%h imp=%b on_d=%b want 000/0/0",
               {R, G, B}, Impresion, ON_d);
    end
    resetM = 1'b0;
    step(2);
    checks++;
    if ({R, G, B} !== 12'hCF9) begin
      errors++;
      $display("FAIL revert got rgb=%h want cf9", {R, G, B});
    end
    H_ON = 1'b0;
    pal_we = 1'b1; pal_addr = 3'd0; pal_data = 12'hF00;
    resetM = 1'b1;
    step(1);
    checks++;
    if (pal_ack !== 1'b0) begin
      errors++;
      $display("FAIL dropack got %b want 0", pal_ack);
    end
    resetM = 1'b0;
    step(1);
    checks++;
    if (pal_ack !== 1'b1) begin
      errors++;
      $display("FAIL rerequest ack got %b want 1", pal_ack);
    end
    pal_we = 1'b0;
    step(1);
    pix(10'd100, 10'd100, 1'b0);
    step(2);
    checks++;
    if ({R, G, B} !== 12'hF00) begin
      errors++;
      $display("FAIL postreset write got rgb=%h want f00", {R, G, B});
    end
    $display("reset sequence done rgb=%h", {R, G, B});
  endtask

  initial begin
    test_reset();
    test_back();
    test_border();
    test_blank();
    test_highlight();
    test_blink();
    test_tick_and_write();
    test_stall();
    test_bad_addr();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rgb_paleta.md
RGB_PALETA -- requirements
Module: rgb_paleta

Interface
REQ-001 Parameter CW, default 4, bits per colour channel (legal 1..8).
REQ-002 Parameter HB0, default 48, first column of the left border band.
REQ-003 Parameter HB1, default 684, first column of the right border band.
REQ-004 Parameter HBW, default 4, width of each vertical border band in columns.
REQ-005 Parameter VB0, default 33, first row of the top band; VB0W, default 2, top band height.
REQ-006 Parameter VB1, default 511, first row of the bottom band; VB1W, default 3, bottom band height.
REQ-007 Parameter BLINK_FRAMES, default 30, frames per blink half-period (legal >= 1).
REQ-008 Ports SHALL be exactly:
- clk  in  1  pixel clock; one clock domain; all state changes on its rising edge
- resetM  in  1  synchronous, active-high reset
- P_FECHA, P_HORA, P_CRONO  in  1 each  active-field selects
- A_A  in  1  edit mode; enables blink of highlighted text
- H_ON, V_ON  in  1 each  visible-region flags
- Qh, Qv  in  10 each  current pixel column / row
- BIT_FUENTE  in  1  font pixel for the current (Qh,Qv)
- pal_we  in  1  palette write request, held until acknowledged
- pal_addr  in  3  palette entry index
- pal_data  in  3*CW  {R,G,B} write value
- pal_ack  out  1  one-cycle write acknowledge
- R, G, B  out  CW each  pixel colour
- Impresion  out  1  pixel is ink (border or font)
- ON_d  out  1  H_ON&V_ON delayed to align with R/G/B

Function
REQ-009 On = H_ON & V_ON; Border = On & (Qh in [HB0,HB0+HBW) or [HB1,HB1+HBW) or Qv in [VB0,VB0+VB0W) or [VB1,VB1+VB1W)); all ranges are half-open, unsigned 10-bit compares.
REQ-010 Highlighted = (P_FECHA & ~P_HORA) | (P_HORA & ~P_FECHA & P_CRONO).
REQ-011 Class priority: ~On -> BLANK; Border -> BORDER; BIT_FUENTE & Highlighted & blink_vis -> HILITE; BIT_FUENTE & Highlighted & ~blink_vis -> BACK; BIT_FUENTE -> FONT; otherwise BACK.
REQ-012 Palette: five registered entries of 3*CW bits: 0 BACK, 1 FONT, 2 HILITE, 3 BORDER, 4 BLANK.
REQ-013 Pipeline: stage 1 registers class and On; stage 2 registers R,G,B = palette[class], Impresion = (class is BORDER or FONT or HILITE), ON_d = stage-1 On; total latency exactly 2 clk from inputs to outputs.
REQ-014 A palette write SHALL be accepted only in a cycle with pal_we=1 and On=0; while On=1 the request stalls with no write and no ack.
REQ-015 On acceptance palette[pal_addr] <= pal_data and pal_ack=1 in the next cycle only; pal_ack SHALL NOT assert on consecutive cycles, so a held pal_we produces at most one write per two cycles.
REQ-016 pal_addr 5..7 SHALL be acknowledged with no palette change.
REQ-017 A write takes effect for classes sampled by stage 2 in the cycle after acceptance.
REQ-018 Frame tick: one-cycle pulse when Qv==0 and Qh==0 and the previous cycle's Qv!=0 or Qh!=0.
REQ-019 Blink: with A_A=1, an internal counter increments on each frame tick; on reaching BLINK_FRAMES-1 with a tick it wraps to 0 and blink_vis toggles.
REQ-020 With A_A=0, counter is held at 0 and blink_vis is forced to 1; when A_A rises, blinking starts with blink_vis=1.
REQ-021 Frame tick and palette write in the same cycle are independent; both SHALL take effect.

Reset
REQ-022 resetM=1 at a clk edge SHALL set R=G=B=0, Impresion=0, ON_d=0, pal_ack=0, both pipeline stages to BLANK/Off, counter=0, blink_vis=1.
REQ-023 Reset SHALL load palette defaults (CW=4): BACK=CF9, FONT=333, HILITE=094, BORDER=360, BLANK=000; for other CW each nibble is scaled as value*(2^CW-1)/15, truncated.
REQ-024 Reset during a pending write SHALL drop it without ack; pal_we still high after reset is treated as a new request.

Verification
REQ-025 Reset, then On=1, Qh=100, Qv=100, BIT_FUENTE=0 -> after 2 clk R,G,B=C,F,9, Impresion=0, ON_d=1.
REQ-026 On=1, Qh=49, BIT_FUENTE=1 -> R,G,B=3,6,0 (border wins), Impresion=1; Qh=52 -> FONT 3,3,3.
REQ-027 P_FECHA=1, P_HORA=0, BIT_FUENTE=1, A_A=1, BLINK_FRAMES=2 -> 0,9,4 for frames 0-1, C,F,9 for frames 2-3, 0,9,4 again at frame 4; A_A=0 -> 0,9,4 steadily.
REQ-028 pal_we=1, pal_addr=0, pal_data=F00 held through active video -> no pal_ack until On=0; ack one cycle later; following BACK pixels output F,0,0.
REQ-029 pal_addr=6 write in blanking -> pal_ack pulses, all five entries unchanged.
REQ-030 resetM=1 mid-frame after a palette write -> outputs 0 next cycle, BACK reverts to C,F,9.
